// File: rtl/score_string_formatter_pkg.sv
// -----------------------------------------------------------------------------
// score_string_formatter_pkg
// Shared font/display constants for the score string path and the state
// encoding of the binary-to-glyph formatter.
//   NUM_CHARS          number of glyph slots in one rendered string
//   CHAR_H_LEN         horizontal size of one glyph cell in the font strip (px)
//   FONT_STRIP_*       dimensions of the font strip bitmap (px)
//   FONT_DIGIT_BASE    glyph index of '0' in the font strip
//   FONT_BLANK_IDX     glyph index of the blank glyph
//   BCD_WIDTH          width of the packed BCD accumulator (one nibble per char)
// -----------------------------------------------------------------------------
package score_string_formatter_pkg;

   localparam int NUM_CHARS         = 10;
   localparam int CHAR_H_LEN        = 15;
   localparam int FONT_STRIP_WIDTH  = 405;
   localparam int FONT_STRIP_HEIGHT = 30;

   localparam int FONT_DIGIT_BASE   = 0;
   localparam int FONT_BLANK_IDX    = 26;

   localparam int BCD_WIDTH         = 4 * NUM_CHARS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      FORMAT  = 2'd2
   } fmt_state_t;

endpackage

// File: rtl/dd_nibble_adjust.sv
// -----------------------------------------------------------------------------
// dd_nibble_adjust
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
//   nibble_in   4-bit BCD digit before correction
//   nibble_out  4-bit corrected digit (4-bit add, no carry out)
// -----------------------------------------------------------------------------
module dd_nibble_adjust (
   input  logic [3:0] nibble_in,
   output logic [3:0] nibble_out
);

   assign nibble_out = (nibble_in >= 4'd5) ? (nibble_in + 4'd3) : nibble_in;

endmodule

// File: rtl/score_string_formatter.sv
// -----------------------------------------------------------------------------
// score_string_formatter
// Converts an unsigned binary value into ten glyph indices for the string
// renderer using a sequential double-dabble conversion (one value bit per
// cycle). The char outputs are held registers that only change on the cycle
// done is raised, so the renderer never sees a half-converted string.
//   clk, rst_n          system clock, asynchronous active-low reset
//   start, value        conversion request and the value it captures
//   busy                conversion in progress
//   done                one-cycle pulse: chars/overflow just updated
//   overflow            value did not fit in ten decimal digits
//   char_1 .. char_10   glyph indices, char_1 is the most significant digit
// -----------------------------------------------------------------------------
module score_string_formatter
   import score_string_formatter_pkg::*;
#(
   parameter int VALUE_WIDTH = 20,
   parameter int cnt_WIDTH   = 10,
   parameter int DIGIT_BASE  = FONT_DIGIT_BASE,
   parameter int BLANK_IDX   = FONT_BLANK_IDX,
   parameter bit ZERO_PAD    = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [VALUE_WIDTH-1:0] value,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow,
   output logic [cnt_WIDTH-1:0]   char_1,
   output logic [cnt_WIDTH-1:0]   char_2,
   output logic [cnt_WIDTH-1:0]   char_3,
   output logic [cnt_WIDTH-1:0]   char_4,
   output logic [cnt_WIDTH-1:0]   char_5,
   output logic [cnt_WIDTH-1:0]   char_6,
   output logic [cnt_WIDTH-1:0]   char_7,
   output logic [cnt_WIDTH-1:0]   char_8,
   output logic [cnt_WIDTH-1:0]   char_9,
   output logic [cnt_WIDTH-1:0]   char_10
);

   localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

   localparam logic [cnt_WIDTH-1:0] BLANK_GLYPH = cnt_WIDTH'(BLANK_IDX);

   function automatic logic [cnt_WIDTH-1:0] digit_glyph(input logic [3:0] d);
      return cnt_WIDTH'(DIGIT_BASE) + cnt_WIDTH'(d);
   endfunction

   fmt_state_t             state;
   fmt_state_t             state_next;

   logic [VALUE_WIDTH-1:0] shift_reg;
   logic [BCD_WIDTH-1:0]   bcd_reg;
   logic [BCD_WIDTH-1:0]   bcd_adj;
   logic [CNT_W-1:0]       bit_cnt;
   logic                   ovf_sticky;

   logic [cnt_WIDTH-1:0]   chars     [NUM_CHARS];
   logic [cnt_WIDTH-1:0]   char_next [NUM_CHARS];
   logic                   done_reg;
   logic                   overflow_reg;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CONVERT;
         // bit_cnt==1 means the last value bit is being shifted in this cycle
         CONVERT: if (bit_cnt == CNT_W'(1)) state_next = FORMAT;
         FORMAT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Per-nibble +3 correction, applied to the current BCD value before the shift
   // ---------------------------------------------------------------------------
   for (genvar n = 0; n < NUM_CHARS; n++) begin : g_adj
      dd_nibble_adjust u_adj (
         .nibble_in  (bcd_reg[4*n +: 4]),
         .nibble_out (bcd_adj[4*n +: 4])
      );
   end

   // ---------------------------------------------------------------------------
   // Glyph formatter: nibble 9 feeds char_1; leading zeros blank unless padded.
   // The least significant slot always shows a digit so zero renders as "0".
   // ---------------------------------------------------------------------------
   always_comb begin
      logic       seen_nz;
      logic [3:0] nib;
      seen_nz = ZERO_PAD;
      nib     = 4'd0;
      for (int i = 0; i < NUM_CHARS; i++) begin
         char_next[i] = BLANK_GLYPH;
      end
      for (int n = NUM_CHARS - 1; n >= 0; n--) begin
         nib = bcd_reg[4*n +: 4];
         if ((nib != 4'd0) || (n == 0)) begin
            seen_nz = 1'b1;
         end
         if (ovf_sticky) begin
            char_next[NUM_CHARS-1-n] = digit_glyph(4'd9);
         end else if (seen_nz) begin
            char_next[NUM_CHARS-1-n] = digit_glyph(nib);
         end else begin
            char_next[NUM_CHARS-1-n] = BLANK_GLYPH;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Conversion datapath and published result registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg    <= '0;
         bcd_reg      <= '0;
         bit_cnt      <= '0;
         ovf_sticky   <= 1'b0;
         done_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         for (int i = 0; i < NUM_CHARS; i++) begin
            chars[i] <= (i == NUM_CHARS - 1) ? digit_glyph(4'd0) : BLANK_GLYPH;
         end
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift_reg  <= value;
                  bcd_reg    <= '0;
                  ovf_sticky <= 1'b0;
                  bit_cnt    <= CNT_W'(VALUE_WIDTH);
               end
            end
            CONVERT: begin
               // {bcd, shift} <<= 1 after correction; the bit pushed out of the
               // top nibble means the value needs an eleventh digit
               bcd_reg    <= {bcd_adj[BCD_WIDTH-2:0], shift_reg[VALUE_WIDTH-1]};
               shift_reg  <= shift_reg << 1;
               ovf_sticky <= ovf_sticky | bcd_adj[BCD_WIDTH-1];
               bit_cnt    <= bit_cnt - CNT_W'(1);
            end
            FORMAT: begin
               for (int i = 0; i < NUM_CHARS; i++) begin
                  chars[i] <= char_next[i];
               end
               overflow_reg <= ovf_sticky;
               done_reg     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign done     = done_reg;
   assign overflow = overflow_reg;

   assign char_1  = chars[0];
   assign char_2  = chars[1];
   assign char_3  = chars[2];
   assign char_4  = chars[3];
   assign char_5  = chars[4];
   assign char_6  = chars[5];
   assign char_7  = chars[6];
   assign char_8  = chars[7];
   assign char_9  = chars[8];
   assign char_10 = chars[9];

endmodule

// File: tb/tb_score_string_formatter.sv
// -----------------------------------------------------------------------------
// tb_score_string_formatter
// Scoreboard bench for score_string_formatter. Three instances: default
// (20-bit, blanked leading zeros), zero-padded 20-bit, and 36-bit. Stimulus
// tasks push the hand-written expected string into a queue; a monitor pops it
// whenever an instance raises done, and otherwise checks that the outputs hold.
// -----------------------------------------------------------------------------
module tb_score_string_formatter;

   typedef logic [9:0][9:0] chars_t;   // [9] = char_1 ... [0] = char_10

   typedef struct {
      int     dut;
      chars_t ch;
      logic   ovf;
      int     due;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start_s [3];
   logic [19:0] value0;
   logic [19:0] value1;
   logic [35:0] value2;
   logic        done_s  [3];
   logic        busy_s  [3];
   logic        ovf_s   [3];
   wire  [9:0]  chw     [3][10];

   exp_t   sb [$];
   exp_t   mon_e;
   chars_t last_pub [3];
   logic   last_ovf [3];
   int     cyc;
   int     errors;
   int     checks;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   score_string_formatter #(.VALUE_WIDTH(20), .ZERO_PAD(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .value(value0),
      .busy(busy_s[0]), .done(done_s[0]), .overflow(ovf_s[0]),
      .char_1(chw[0][0]), .char_2(chw[0][1]), .char_3(chw[0][2]), .char_4(chw[0][3]),
      .char_5(chw[0][4]), .char_6(chw[0][5]), .char_7(chw[0][6]), .char_8(chw[0][7]),
      .char_9(chw[0][8]), .char_10(chw[0][9])
   );

   score_string_formatter #(.VALUE_WIDTH(20), .ZERO_PAD(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .value(value1),
      .busy(busy_s[1]), .done(done_s[1]), .overflow(ovf_s[1]),
      .char_1(chw[1][0]), .char_2(chw[1][1]), .char_3(chw[1][2]), .char_4(chw[1][3]),
      .char_5(chw[1][4]), .char_6(chw[1][5]), .char_7(chw[1][6]), .char_8(chw[1][7]),
      .char_9(chw[1][8]), .char_10(chw[1][9])
   );

   score_string_formatter #(.VALUE_WIDTH(36), .ZERO_PAD(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .value(value2),
      .busy(busy_s[2]), .done(done_s[2]), .overflow(ovf_s[2]),
      .char_1(chw[2][0]), .char_2(chw[2][1]), .char_3(chw[2][2]), .char_4(chw[2][3]),
      .char_5(chw[2][4]), .char_6(chw[2][5]), .char_7(chw[2][6]), .char_8(chw[2][7]),
      .char_9(chw[2][8]), .char_10(chw[2][9])
   );

   // ' ' -> blank glyph 26, '0'..'9' -> digit glyph 0..9
   function automatic chars_t str2chars(input string s);
      chars_t r;
      for (int i = 0; i < 10; i++) begin
         if (s[i] == " ") r[9-i] = 10'd26;
         else             r[9-i] = 10'(int'(s[i]) - 48);
      end
      return r;
   endfunction

   function automatic chars_t pack_dut(input int d);
      chars_t r;
      for (int i = 0; i < 10; i++) r[9-i] = chw[d][i];
      return r;
   endfunction

   function automatic string fmt(input chars_t c);
      string s;
      s = "";
      for (int i = 9; i >= 0; i--) s = {s, $sformatf("%0d ", c[i])};
      return s;
   endfunction

   function automatic void chk_chars(input string name, input chars_t act, input chars_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: chars got [%s] want [%s]", name, fmt(act), fmt(exp));
      end
   endfunction

   function automatic void chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endfunction

   function automatic void chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endfunction

   // Monitor: reset values while rst_n is low, scoreboard on done, hold otherwise
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            chk_bit($sformatf("d%0d reset busy", d), busy_s[d], 1'b0);
            chk_bit($sformatf("d%0d reset done", d), done_s[d], 1'b0);
            chk_bit($sformatf("d%0d reset overflow", d), ovf_s[d], 1'b0);
            chk_chars($sformatf("d%0d reset chars", d), pack_dut(d), str2chars("         0"));
            last_pub[d] = str2chars("         0");
            last_ovf[d] = 1'b0;
         end else if (done_s[d]) begin
            chk_bit($sformatf("d%0d busy at done", d), busy_s[d], 1'b0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL d%0d unexpected done: got done=1 want no done at cycle %0d", d, cyc);
               last_pub[d] = pack_dut(d);
               last_ovf[d] = ovf_s[d];
            end else begin
               mon_e = sb.pop_front();
               chk_int($sformatf("d%0d done source", d), d, mon_e.dut);
               chk_int($sformatf("d%0d done cycle", d), cyc, mon_e.due);
               chk_chars($sformatf("d%0d result", d), pack_dut(d), mon_e.ch);
               chk_bit($sformatf("d%0d overflow", d), ovf_s[d], mon_e.ovf);
               last_pub[d] = mon_e.ch;
               last_ovf[d] = mon_e.ovf;
            end
         end else begin
            chk_chars($sformatf("d%0d hold chars", d), pack_dut(d), last_pub[d]);
            chk_bit($sformatf("d%0d hold overflow", d), ovf_s[d], last_ovf[d]);
         end
      end
   end

   function automatic int width_of(input int d);
      return (d == 2) ? 36 : 20;
   endfunction

   task automatic drive_value(input int d, input logic [35:0] v);
      case (d)
         0:       value0 = v[19:0];
         1:       value1 = v[19:0];
         default: value2 = v;
      endcase
   endtask

   // Pulse start for one edge and queue the expected result
   task automatic issue(input int d, input logic [35:0] v, input string s, input logic ovf);
      exp_t e;
      @(negedge clk);
      start_s[d] = 1'b1;
      drive_value(d, v);
      @(negedge clk);
      start_s[d] = 1'b0;
      drive_value(d, 36'h5_A5A5_A5A5);
      e.dut = d;
      e.ch  = str2chars(s);
      e.ovf = ovf;
      e.due = cyc + width_of(d) + 1;
      sb.push_back(e);
      chk_bit($sformatf("d%0d busy after accept", d), busy_s[d], 1'b1);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 80 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got %0d pending results want 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic run(input int d, input logic [35:0] v, input string s, input logic ovf);
      issue(d, v, s, ovf);
      drain($sformatf("d%0d value %0d", d, v));
   endtask

   initial begin
      exp_t e;
      int   c0;
      errors = 0;
      checks = 0;
      cyc    = 0;
      rst_n  = 1'b0;
      for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
      value0 = '0;
      value1 = '0;
      value2 = '0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      // basic values, blanked leading zeros
      run(0, 36'd1234, "      1234", 1'b0);
      run(0, 36'd0,    "         0", 1'b0);
      run(0, 36'd1000, "      1000", 1'b0);
      run(0, 36'd10,   "        10", 1'b0);

      // zero padding
      run(1, 36'd42, "0000000042", 1'b0);
      run(1, 36'd0,  "0000000000", 1'b0);

      // max 20-bit value, then start held across done for a back-to-back run
      @(negedge clk);
      start_s[0] = 1'b1;
      value0     = 20'd1048575;
      @(negedge clk);
      c0    = cyc;
      value0 = 20'd7;
      e.dut = 0; e.ch = str2chars("   1048575"); e.ovf = 1'b0; e.due = c0 + 21;
      sb.push_back(e);
      e.dut = 0; e.ch = str2chars("         7"); e.ovf = 1'b0; e.due = c0 + 22 + 21;
      sb.push_back(e);
      chk_bit("d0 busy after held start", busy_s[0], 1'b1);
      while (cyc < c0 + 22) @(negedge clk);
      start_s[0] = 1'b0;
      drain("back-to-back");

      // start while busy is ignored
      issue(0, 36'd1234, "      1234", 1'b0);
      repeat (4) @(negedge clk);
      start_s[0] = 1'b1;
      value0     = 20'd99;
      @(negedge clk);
      start_s[0] = 1'b0;
      drain("ignored start");
      repeat (30) @(negedge clk);

      // reset in the middle of a conversion of 555
      issue(0, 36'd555, "       555", 1'b0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk_bit("d0 busy after reset", busy_s[0], 1'b0);
      repeat (30) @(negedge clk);
      run(0, 36'd555, "       555", 1'b0);

      // 36-bit overflow boundaries
      run(2, 36'd68719476735, "9999999999", 1'b1);
      run(2, 36'd9999999999,  "9999999999", 1'b0);
      run(2, 36'd10000000000, "9999999999", 1'b1);
      run(2, 36'd1234,        "      1234", 1'b0);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
